// File: rtl/pe_pkg.sv
// Shared constants and saturation helper for the PE result collector.
package pe_pkg;

  localparam int DEF_RES_W = 37;
  localparam int DEF_OUT_W = 16;
  localparam int DEF_SHIFT = 8;
  localparam int SAT_IN_W  = 64;

  typedef enum logic [1:0] {
    SAT_NONE = 2'b00,
    SAT_HI   = 2'b01,
    SAT_LO   = 2'b10
  } sat_t;

  // Classifies a sign-extended value against the signed range of out_w bits.
  function automatic sat_t sat_width(input logic signed [SAT_IN_W-1:0] x,
                                     input int unsigned out_w);
    logic signed [SAT_IN_W-1:0] max_v;
    logic signed [SAT_IN_W-1:0] min_v;
    sat_t r;
    max_v = (64'sd1 <<< (out_w - 32'd1)) - 64'sd1;
    min_v = -(64'sd1 <<< (out_w - 32'd1));
    if (x > max_v) begin
      r = SAT_HI;
    end else if (x < min_v) begin
      r = SAT_LO;
    end else begin
      r = SAT_NONE;
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_sync_fifo.sv
// Single-clock FIFO with occupancy counter; a word pushed into an empty FIFO
// becomes visible only on the following cycle.
module pe_sync_fifo
  import pe_pkg::*;
#(
  parameter int W     = DEF_OUT_W,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
  localparam logic [CW-1:0] OCC_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] OCC_FULL = CW'(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] occ_r;

  assign full  = (occ_r == OCC_FULL);
  assign empty = (occ_r == {CW{1'b0}});
  assign dout  = empty ? {W{1'b0}} : mem_r[rd_ptr_r];

  // Storage array, written at the current write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      occ_r    <= {CW{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   occ_r <= occ_r + OCC_ONE;
        2'b01:   occ_r <= occ_r - OCC_ONE;
        default: occ_r <= occ_r;
      endcase
    end
  end

endmodule

// File: rtl/pe_result_collector.sv
// Rescales PE results (round, shift, saturate) and buffers them in a FIFO.
// Optional ReLU clamp before the FIFO: define PE_RESULT_RELU_EN.
module pe_result_collector
  import pe_pkg::*;
#(
  parameter int RES_W = DEF_RES_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SHIFT = DEF_SHIFT,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RES_W-1:0] result,
  input  logic             valid,
  output logic [OUT_W-1:0] out_dat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf,
  output logic             sat,
  output logic [15:0]      cnt
);

  // One guard bit keeps the rounding add from overflowing; RES_W must stay below SAT_IN_W.
  localparam int EXT_W  = RES_W + 1;
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [EXT_W-1:0] RND_C = (SHIFT > 0) ? (EXT_W'(1'b1) << RND_SH) : {EXT_W{1'b0}};
  localparam logic [OUT_W-1:0] MAX_C = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_C = {1'b1, {(OUT_W-1){1'b0}}};

  logic signed [EXT_W-1:0]    ext_s;
  logic signed [EXT_W-1:0]    rnd_s;
  logic signed [EXT_W-1:0]    shf_s;
  logic signed [SAT_IN_W-1:0] wide_s;
  sat_t                       sat_code_s;
  logic [OUT_W-1:0]           clip_s;
  logic [OUT_W-1:0]           word_s;
  logic                       clamped_s;

  logic                       s1_vld_r;
  logic [OUT_W-1:0]           s1_dat_r;
  logic                       sat_r;
  logic                       ovf_r;
  logic [15:0]                cnt_r;

  logic                       push_s;
  logic                       pop_s;
  logic                       full_s;
  logic                       empty_s;
  logic                       drop_s;

  // Round half up, arithmetic shift, then clamp to the output range.
  always_comb begin
    ext_s      = {result[RES_W-1], result};
    rnd_s      = ext_s + $signed(RND_C);
    shf_s      = rnd_s >>> SHIFT;
    wide_s     = {{(SAT_IN_W-EXT_W){shf_s[EXT_W-1]}}, shf_s};
    sat_code_s = sat_width(wide_s, OUT_W);
    clamped_s  = 1'b0;
    case (sat_code_s)
      SAT_HI: begin
        clip_s    = MAX_C;
        clamped_s = 1'b1;
      end
      SAT_LO: begin
        clip_s    = MIN_C;
        clamped_s = 1'b1;
      end
      default: clip_s = shf_s[OUT_W-1:0];
    endcase
`ifdef PE_RESULT_RELU_EN
    word_s = clip_s[OUT_W-1] ? {OUT_W{1'b0}} : clip_s;
`else
    word_s = clip_s;
`endif
  end

  // Stage-1 register and sticky saturation flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_r <= 1'b0;
      s1_dat_r <= {OUT_W{1'b0}};
      sat_r    <= 1'b0;
    end else begin
      s1_vld_r <= valid;
      if (valid) begin
        s1_dat_r <= word_s;
      end
      if (valid && clamped_s) begin
        sat_r <= 1'b1;
      end
    end
  end

  // A full FIFO still accepts when the head leaves in the same cycle.
  assign pop_s  = ~empty_s & out_ready;
  assign push_s = s1_vld_r & (~full_s | pop_s);
  assign drop_s = s1_vld_r & full_s & ~pop_s;

  // Accepted-word counter and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 16'd0;
      ovf_r <= 1'b0;
    end else begin
      if (push_s) begin
        cnt_r <= cnt_r + 16'd1;
      end
      if (drop_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  pe_sync_fifo #(
    .W     (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .din   (s1_dat_r),
    .dout  (out_dat),
    .full  (full_s),
    .empty (empty_s)
  );

  assign out_valid = ~empty_s;
  assign ovf       = ovf_r;
  assign sat       = sat_r;
  assign cnt       = cnt_r;

endmodule

// File: doc/pe_result_collector.md
PE_RESULT_COLLECTOR -- requirements
Module: pe_result_collector

Interface
REQ-001 SHALL have parameter RES_W, default 37, width of the PE result word.
REQ-002 SHALL have parameter OUT_W, default 16, width of the rescaled output word.
REQ-003 SHALL have parameter SHIFT, default 8, arithmetic right-shift applied to the result (0..RES_W-1).
REQ-004 SHALL have parameter DEPTH, default 8, output FIFO entries (power of two, >=2).
REQ-005 SHALL have port clk, input, 1, single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port result, input, RES_W, signed PE result, sampled only when valid=1.
REQ-008 SHALL have port valid, input, 1, PE result-valid strobe, one result per high cycle, no backpressure toward PE.
REQ-009 SHALL have port out_dat, output, OUT_W, signed rescaled result at FIFO head.
REQ-010 SHALL have port out_valid, output, 1, FIFO non-empty.
REQ-011 SHALL have port out_ready, input, 1, downstream accept; transfer when out_valid & out_ready.
REQ-012 SHALL have port ovf, output, 1, sticky flag: a result was dropped because the FIFO was full.
REQ-013 SHALL have port sat, output, 1, sticky flag: at least one result saturated.
REQ-014 SHALL have port cnt, output, 16, number of results accepted into the FIFO, wraps at 2^16.

Function
REQ-015 SHALL compute stage 1 on valid: r = (result + 2^(SHIFT-1)) >>> SHIFT (round half up; no rounding term when SHIFT=0), computed at RES_W+1 bits so the add never overflows.
REQ-016 SHALL saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and set sat when clamping occurs.
REQ-017 SHALL register the saturated value and a stage valid bit (s1_vld) one cycle after valid.
REQ-018 SHALL push the stage-1 word into the FIFO when s1_vld=1 and (FIFO not full, or full with a pop in the same cycle).
REQ-019 SHALL drop the stage-1 word, set ovf, and leave cnt unchanged when s1_vld=1, FIFO full and no pop that cycle.
REQ-020 SHALL give latency: valid high on edge N -> out_valid high after edge N+2 when the FIFO was empty.
REQ-021 SHALL present out_dat as the FIFO head with out_dat held stable while out_valid=1 and out_ready=0.
REQ-022 SHALL support simultaneous push and pop when empty-then-nonempty: a push into an empty FIFO is not poppable the same cycle.
REQ-023 SHALL wrap read/write pointers modulo DEPTH and keep an occupancy counter 0..DEPTH; out_valid = (occupancy != 0).
REQ-024 SHALL accept back-to-back valid every cycle at full throughput while out_ready=1.

Reset
REQ-025 SHALL, while rst_n=0, clear s1_vld, pointers, occupancy, cnt, ovf, sat and drive out_valid=0, out_dat=0 asynchronously.
REQ-026 SHALL discard any in-flight stage-1 word and FIFO contents on reset mid-operation; first valid after release is processed normally.

Configuration
REQ-027 SHALL, when macro PE_RESULT_RELU_EN is defined, clamp negative saturated values to 0 before the FIFO (sat unaffected by the ReLU clamp).
REQ-028 SHALL, without PE_RESULT_RELU_EN, pass signed values unmodified.

Structure
REQ-029 SHALL place default RES_W/OUT_W/SHIFT constants and a saturate-width function in shared package pe_pkg.
REQ-030 SHALL implement the FIFO as sub-module pe_sync_fifo (clk, rst_n, push, pop, din, dout, full, empty).

Verification
REQ-031 SHALL check SHIFT=8, result=256 then 384 -> out_dat 1 then 2, out_valid two cycles after each valid.
REQ-032 SHALL check result=2^30 -> out_dat=32767, sat=1; result=-2^30 -> -32768 (or 0 with PE_RESULT_RELU_EN).
REQ-033 SHALL check result=-384 -> out_dat=-1 (round half up of -1.5); with PE_RESULT_RELU_EN -> 0.
REQ-034 SHALL check out_ready=0, 10 consecutive valids -> 8 entries held, ovf=1, cnt=8, then draining yields first 8 values in order.
REQ-035 SHALL check FIFO full with out_ready=1 and valid every cycle -> no drop, ovf stays 0, cnt increments each cycle.
REQ-036 SHALL check rst_n pulsed low 2 ns mid-stream -> out_valid=0, cnt=0, ovf=0 immediately; next valid of 1<<8 yields out_dat=1.
